seven_seg_axil_slave: RTL
=========================

# seven_seg_axil_slave

AXI4-Lite responder for the seven-segment display peripheral: the slave end of the link that the VIP master in the block-design bench drives. It decodes four 32-bit read/write registers and drives a time-multiplexed four-digit, active-low seven-segment display from them. The block sits behind the interconnect in place of the generated slave template and connects directly to board pins.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; bits [3:2] select the register.
- SCAN_DIV, 100000: ACLK cycles per digit in the display scan; minimum 2.
- ACLK  in  1  sole clock; all logic is rising-edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  4 / S_AXI_AWPROT in 3 (ignored) / S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1  write address channel.
- S_AXI_WDATA  in  32 / S_AXI_WSTRB in 4 / S_AXI_WVALID in 1 / S_AXI_WREADY out 1  write data channel.
- S_AXI_BRESP  out  2 / S_AXI_BVALID out 1 / S_AXI_BREADY in 1  write response channel.
- S_AXI_ARADDR  in  4 / S_AXI_ARPROT in 3 (ignored) / S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1  read address channel.
- S_AXI_RDATA  out  32 / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1  read data channel.
- SEG_N  out  7  segments {g,f,e,d,c,b,a}; active-low.
- DP_N  out  1  decimal point; active-low.
- AN_N  out  4  digit anodes; active-low, one-hot.

## Operation
- Registers (offsets 0x0, 0x4, 0x8, 0xC) are all full 32-bit read/write. Every register reads back exactly what was written.
  - VALUE (0x0): nibble k drives digit k.
  - CTRL (0x4): bit 0 enables the display; bits [7:4] are the decimal-point mask per digit.
  - BLANK (0x8): bits [3:0] blank the corresponding digit.
  - SCRATCH (0xC): no hardware function.
- Write byte lanes are applied per WSTRB. With WSTRB = 0 the register is unchanged, but the block still returns a response.
- Address bits [1:0] are ignored. BRESP and RRESP are always 2'b00 (OKAY).
- Write FSM, states W_IDLE → W_COLLECT → W_RESP:
  - AW and W may arrive in either order or in the same cycle. Each is latched once, and its READY drops after its handshake.
  - When both are held, the register commits and BVALID rises.
  - BVALID is held until the cycle BREADY is high, then the FSM returns to W_IDLE.
- Read FSM, states R_IDLE → R_DATA:
  - On the AR handshake, RDATA is captured from the register file and RVALID rises.
  - RVALID and RDATA are held stable until RREADY, then the FSM returns to R_IDLE.
- The read and write FSMs are independent and may be active simultaneously.
- Display scan:
  - A counter runs 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
  - AN_N has a 0 only at the current index.
  - SEG_N is the hex-font decode of the current nibble. DP_N = ~CTRL[4+idx].
  - If CTRL[0] = 0, or BLANK[idx] = 1, then AN_N = 4'hF for that digit slot.

## Timing
- Reset values: all registers 0, AWREADY/WREADY/ARREADY 0, BVALID/RVALID 0, RDATA 0, BRESP/RRESP 0, SEG_N 7'h7F, DP_N 1, AN_N 4'hF, scan counter and index 0.
- AWREADY, WREADY and ARREADY go high on the first edge after ARESET is deasserted, then follow the FSMs.
- Write commit and BVALID rise occur on the edge that completes the later of the AW and W handshakes. For the same-cycle case, BVALID is high 1 cycle after AWVALID & WVALID are first seen with the readies high.
- Read latency: RVALID is high on the cycle after the AR handshake.
- When a write commit and an AR handshake fall on the same edge to the same register, the read returns the old value.
- While BVALID or RVALID is held, no new AW/W or AR is accepted (the corresponding READY stays 0).
- Display outputs are registered. A VALUE or CTRL change is visible on SEG_N within 1 cycle.
- ARESET mid-transaction aborts it. VALID signals drop on the next edge and no response is issued.

## Structure
- Package seven_seg_pkg holds:
  - register offset localparams and CTRL bit positions;
  - the 16-entry hex-to-segment constant (0 → 7'b1000000, active-low);
  - the write and read FSM state enums.
- Sub-module seven_seg_scan contains the scan counter, index, and anode/segment/DP output registers. Inputs are VALUE[15:0], CTRL[7:0] and BLANK[3:0].
- The top level holds the AXI FSMs and the register file.

## Test plan
- Reset, then write 0x1, 0x2, 0x3, 0x4 to offsets 0x0..0xC and read them back → RDATA 0x1..0x4, all responses OKAY.
- Present AW two cycles before W, then W before AW, at offset 0x8 with WSTRB = 4'b0010 and data 0xAABBCCDD over an old value of 0 → the register reads 0x0000CC00, and exactly one BVALID per write.
- Hold BREADY/RREADY low for 5 cycles → BVALID/RVALID and RDATA stay stable, no further READY asserted, handshakes complete when released.
- Write at offset 0x0 commits on the same edge as an AR handshake at 0x0 (old value 0x5, new 0x9) → the read returns 0x5, and a subsequent read returns 0x9.
- SCAN_DIV = 4, VALUE = 0x3210, CTRL = 0x11 → AN_N cycles E,D,B,7 every 4 cycles, SEG_N 40,79,24,30 in step, DP_N 0 only on digit 0. Then BLANK = 0x2 → AN_N stays F during the digit-1 slot.
- Assert ARESET with RVALID pending → next edge RVALID = 0, AN_N = F, all registers read 0 afterwards.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
// Shared definitions for the seven-segment AXI4-Lite peripheral:
//   - register word offsets (address bits [3:2]) and CTRL bit positions
//   - the 16-entry hex font, active-low, bit order {g,f,e,d,c,b,a}
//   - state encodings for the AXI write and read FSMs
package seven_seg_pkg;

  localparam logic [1:0] REG_VALUE   = 2'd0;  // byte offset 0x0
  localparam logic [1:0] REG_CTRL    = 2'd1;  // byte offset 0x4
  localparam logic [1:0] REG_BLANK   = 2'd2;  // byte offset 0x8
  localparam logic [1:0] REG_SCRATCH = 2'd3;  // byte offset 0xC

  localparam int CTRL_EN_BIT = 0;  // display enable
  localparam int CTRL_DP_LSB = 4;  // CTRL[7:4] = decimal-point mask per digit

  // Entry k is the segment pattern for hex digit k; a 0 lights the segment.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,  // nothing latched yet
    W_COLLECT = 2'd1,  // one of AW / W latched, waiting for the other
    W_RESP    = 2'd2   // register committed, BVALID held until BREADY
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,     // waiting for AR
    R_DATA = 1'b1      // RVALID held until RREADY
  } rd_state_e;

endpackage

// File: rtl/seven_seg_scan.sv
// seven_seg_scan
// Time-multiplexes four hex digits onto an active-low seven-segment display.
// Ports:
//   clk_i, srst_i   clock and synchronous active-high reset
//   value_i[15:0]   nibble k is shown on digit k
//   ctrl_i[7:0]     bit 0 display enable, bits [7:4] decimal-point mask
//   blank_i[3:0]    per-digit blank
//   seg_n_o[6:0]    segments {g,f,e,d,c,b,a}, active-low, registered
//   dp_n_o          decimal point, active-low, registered
//   an_n_o[3:0]     digit anodes, active-low one-hot, registered
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic [15:0] value_i,
  input  logic [7:0]  ctrl_i,
  input  logic [3:0]  blank_i,
  output logic [6:0]  seg_n_o,
  output logic        dp_n_o,
  output logic [3:0]  an_n_o
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;
  logic [3:0]    an_n_q, an_n_d;
  logic [3:0]    nibble;
  logic [3:0]    dp_mask;
  logic          unused_ok;

  assign unused_ok = ^ctrl_i[3:1];
  assign dp_mask   = ctrl_i[CTRL_DP_LSB +: 4];
  assign nibble    = value_i[{idx_q, 2'b00} +: 4];

  // Outputs are decoded from the live register inputs every cycle, so a
  // register write shows up on the pins one edge later.
  always_comb begin
    seg_n_d = HEX_FONT[nibble];
    dp_n_d  = ~dp_mask[idx_q];
    an_n_d  = 4'hF;
    if (ctrl_i[CTRL_EN_BIT] && !blank_i[idx_q]) begin
      an_n_d = ~(4'b0001 << idx_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      seg_n_q <= 7'h7F;
      dp_n_q  <= 1'b1;
      an_n_q  <= 4'hF;
    end else begin
      if (cnt_q == CW'(SCAN_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      an_n_q  <= an_n_d;
    end
  end

  assign seg_n_o = seg_n_q;
  assign dp_n_o  = dp_n_q;
  assign an_n_o  = an_n_q;

endmodule

// File: rtl/seven_seg_axil_slave.sv
// seven_seg_axil_slave
// AXI4-Lite slave with four 32-bit R/W registers (VALUE, CTRL, BLANK,
// SCRATCH) driving a four-digit multiplexed seven-segment display.
// Ports:
//   ACLK, ARESET        clock and synchronous active-high reset
//   S_AXI_AW*/W*/B*     write address, data and response channels
//   S_AXI_AR*/R*        read address and data channels
//   SEG_N, DP_N, AN_N   active-low display pins
module seven_seg_axil_slave
  import seven_seg_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int SCAN_DIV           = 100000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [6:0]                      SEG_N,
  output logic                            DP_N,
  output logic [3:0]                      AN_N
);

  logic [31:0] regs_q [4];

  // Write channel state
  wr_state_e   wstate_q, wstate_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [1:0]  awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_fire, w_fire;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  // Read channel state
  rd_state_e   rstate_q, rstate_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ar_fire;

  logic        unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_fire = S_AXI_AWVALID & awready_q;
  assign w_fire  = S_AXI_WVALID & wready_q;
  assign ar_fire = S_AXI_ARVALID & arready_q;

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wr_en     = 1'b0;
    // Use the latched copy if that half arrived earlier, else the live bus.
    wr_idx    = aw_held_q ? awaddr_q : S_AXI_AWADDR[3:2];
    wr_data   = w_held_q ? wdata_q : S_AXI_WDATA;
    wr_strb   = w_held_q ? wstrb_q : S_AXI_WSTRB;
    case (wstate_q)
      W_IDLE, W_COLLECT: begin
        if (aw_fire) begin
          awaddr_d  = S_AXI_AWADDR[3:2];
          aw_held_d = 1'b1;
          awready_d = 1'b0;
        end
        if (w_fire) begin
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
          w_held_d = 1'b1;
          wready_d = 1'b0;
        end
        if ((aw_held_q | aw_fire) && (w_held_q | w_fire)) begin
          // Commit on the edge that completes the later handshake.
          wr_en     = 1'b1;
          bvalid_d  = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          wstate_d  = W_RESP;
        end else if (aw_held_q | aw_fire | w_held_q | w_fire) begin
          wstate_d = W_COLLECT;
        end else begin
          // Idle with nothing latched: open both channels (covers the first
          // cycle after reset, when the readies start low).
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_fire) begin
          // regs_q still holds the pre-commit value on a same-edge write.
          rdata_d   = regs_q[S_AXI_ARADDR[3:2]];
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          rstate_d  = R_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= 2'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  // Register file: one block per register, byte lanes gated by WSTRB.
  for (genvar gi = 0; gi < 4; gi++) begin : g_reg
    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        regs_q[gi] <= 32'd0;
      end else if (wr_en && (wr_idx == 2'(gi))) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) begin
            regs_q[gi][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

  seven_seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk_i   (ACLK),
    .srst_i  (ARESET),
    .value_i (regs_q[REG_VALUE][15:0]),
    .ctrl_i  (regs_q[REG_CTRL][7:0]),
    .blank_i (regs_q[REG_BLANK][3:0]),
    .seg_n_o (SEG_N),
    .dp_n_o  (DP_N),
    .an_n_o  (AN_N)
  );

endmodule
